// File: rtl/aes_core_sched.sv
`default_nettype none
// ============================================================================
// Module : aes_core_sched
// Shares one AES-128/AES-256 round datapath between NREQ requesters.
// Round-robin arbitration with a single job in flight. Per job it sequences
// the round core (mode, data/key load enables, key half select, datapath
// sync reset) and presents a tagged completion until it is accepted.
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   req_valid/req_type    per-requester request and key size (1 = AES-256)
//   req_ready             one-hot grant, only in IDLE
//   stall                 freezes sequencing in LOAD/ROUND/FINAL
//   core_*                round-core control, decoded from registers
//   busy                  job in flight
//   rsp_valid/rsp_id/rsp_ready  tagged completion handshake
// Revision: 1.0 - initial release
// ============================================================================
module aes_core_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ-1:0] req_type,
  output logic [NREQ-1:0] req_ready,
  input  logic            stall,
  output logic            core_reset,
  output logic [1:0]      core_mode,
  output logic            core_d_en,
  output logic            core_k_en,
  output logic            core_key_sel,
  output logic [3:0]      core_round,
  output logic            busy,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  input  logic            rsp_ready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_id;
  logic           r_type;
  logic [3:0]     r_round;
  logic [3:0]     w_round_nxt;

  logic            w_found;
  logic            w_accept;
  logic [IDW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_gnt;
  logic [IDW:0]    w_cand;
  logic [IDW:0]    w_inc;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [3:0]      w_last_round;
  logic [3:0]      w_nr;

  assign w_last_round = r_type ? 4'd13 : 4'd9;
  assign w_nr         = r_type ? 4'd14 : 4'd10;

  // Round-robin search: candidates rr_ptr, rr_ptr+1, ... wrapped mod NREQ.
  // The inner loop turns the candidate number into a one-hot pick so no
  // index wider than the request vector is ever used.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    w_cand    = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDW+1)'(i);
      if (w_cand >= (IDW+1)'(NREQ)) begin
        w_cand = w_cand - (IDW+1)'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && (w_cand == (IDW+1)'(j)) && req_valid[j]) begin
          w_found   = 1'b1;
          w_gnt_idx = IDW'(j);
          w_gnt[j]  = 1'b1;
        end
      end
    end
  end

  assign w_inc     = {1'b0, w_gnt_idx} + {{IDW{1'b0}}, 1'b1};
  assign w_ptr_nxt = (w_inc == (IDW+1)'(NREQ)) ? '0 : w_inc[IDW-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_round_nxt  = r_round;
    w_accept     = 1'b0;
    req_ready    = '0;
    core_reset   = 1'b0;
    core_mode    = 2'b11;
    core_d_en    = 1'b0;
    core_k_en    = 1'b0;
    core_key_sel = 1'b0;
    core_round   = r_round;
    busy         = 1'b1;
    rsp_valid    = 1'b0;
    rsp_id       = '0;
    case (r_state)
      S_IDLE: begin
        core_reset = 1'b1;
        core_d_en  = 1'b1;
        core_k_en  = 1'b1;
        busy       = 1'b0;
        req_ready  = w_gnt;
        if (w_found) begin
          w_accept    = 1'b1;
          w_round_nxt = 4'd0;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        core_d_en    = 1'b1;
        core_k_en    = 1'b1;
        core_key_sel = r_type;
        if (!stall) begin
          w_round_nxt = 4'd1;
          w_state_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        core_mode    = 2'b00;
        core_key_sel = r_type;
        // Second key half for AES-256 enters on the first middle round.
        core_k_en    = r_type && (r_round == 4'd1);
        if (!stall) begin
          if (r_round == w_last_round) begin
            w_round_nxt = w_nr;
            w_state_nxt = S_FINAL;
          end else begin
            w_round_nxt = r_round + 4'd1;
          end
        end
      end
      S_FINAL: begin
        core_mode    = 2'b10;
        core_key_sel = r_type;
        if (!stall) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = r_id;
        if (rsp_ready) begin
          // Clear the round so IDLE presents round 0 as after reset.
          w_round_nxt = 4'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_type   <= 1'b0;
      r_round  <= 4'd0;
    end else begin
      r_round <= w_round_nxt;
      if (w_accept) begin
        r_type   <= |(req_type & w_gnt);
        r_id     <= w_gnt_idx;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_core_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_core_sched
// Directed bench for aes_core_sched with a response scoreboard: every grant
// pushes the expected id and first rsp_valid cycle; a monitor pops and
// compares on each new response.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_core_sched;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_type = '0;
  logic [NREQ-1:0] req_ready;
  logic            stall = 1'b0;
  logic            core_reset;
  logic [1:0]      core_mode;
  logic            core_d_en;
  logic            core_k_en;
  logic            core_key_sel;
  logic [3:0]      core_round;
  logic            busy;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic            rsp_ready = 1'b1;

  aes_core_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_type     (req_type),
    .req_ready    (req_ready),
    .stall        (stall),
    .core_reset   (core_reset),
    .core_mode    (core_mode),
    .core_d_en    (core_d_en),
    .core_k_en    (core_k_en),
    .core_key_sel (core_key_sel),
    .core_round   (core_round),
    .busy         (busy),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_ready    (rsp_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int q_id[$];
  int q_cyc[$];
  int exp_ptr = 0;
  logic prev_rv = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [14:0] reset_vec();
    return {req_ready, core_reset, core_mode, core_d_en, core_k_en, core_key_sel,
            core_round, busy, rsp_valid, rsp_id};
  endfunction
  localparam logic [14:0] RESET_EXP = 15'b00_1_11_1_1_0_0000_0_0_0;

  function automatic logic [10:0] seq_vec();
    return {core_reset, core_mode, core_d_en, core_k_en, core_key_sel, core_round, busy};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    int eid;
    int ecy;
    if (reset_n && rsp_valid && !prev_rv) begin
      if (q_id.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        eid = q_id.pop_front();
        ecy = q_cyc.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(eid));
        chk("rsp_cycle", 32'(cyc), 32'(ecy));
      end
    end
    prev_rv = rsp_valid;
  end

  task automatic wait_grant(input int limit, output bit ok);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < limit);
    ok = (req_ready != '0);
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < limit);
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  // One job: request from g, trace every sequencing cycle, check response.
  task automatic run_job(input int g, input int typ, input int stall_r, input int stall_n,
                         input int hold, output int t_g, output int t_r);
    int nr;
    int reps;
    bit ok;
    logic [10:0] e;
    nr = (typ != 0) ? 14 : 10;
    @(posedge clk);
    #1;
    req_valid = NREQ'(1 << g);
    req_type  = (typ != 0) ? NREQ'(1 << g) : '0;
    if (hold > 0) rsp_ready = 1'b0;
    wait_grant(20, ok);
    t_g = cyc;
    t_r = cyc;
    if (!ok) return;
    chk("grant", 32'(req_ready), 32'(1 << g));
    exp_ptr = (g + 1) % NREQ;
    q_id.push_back(g);
    q_cyc.push_back(t_g + nr + 2 + stall_n);
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int c = 1; c <= nr + 1; c++) begin
      reps = (c - 1 == stall_r) ? stall_n + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        @(negedge clk);
        e = {1'b0,
             (c == 1) ? 2'b11 : ((c == nr + 1) ? 2'b10 : 2'b00),
             (c == 1),
             (c == 1) || (typ != 0 && c == 2),
             (typ != 0),
             4'(c - 1),
             1'b1};
        chk("seq", 32'(seq_vec()), 32'(e));
        stall = (c - 1 == stall_r) && (r < stall_n);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    t_r = cyc;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_ctrl", 32'({core_reset, core_mode, core_d_en, core_k_en}), 32'(5'b0_11_0_0));
    if (hold > 0) begin
      req_valid = 2'b01;
      for (int h = 1; h <= hold; h++) begin
        @(negedge clk);
        chk("rsp_held", 32'(rsp_valid), 32'd1);
        chk("no_grant_in_resp", 32'(req_ready), 32'd0);
        if (h == hold) rsp_ready = 1'b1;
      end
    end
  endtask

  initial begin
    int tg;
    int tr;
    int tg2;
    int tr2;
    bit ok;
    bit seen;

    // Reset values
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(reset_vec()), 32'(RESET_EXP));
    reset_n = 1'b1;

    // AES-128 from requester 0
    run_job(0, 0, -1, 0, 0, tg, tr);
    chk("lat128", 32'(tr - tg), 32'd12);

    // AES-256 from requester 1
    run_job(1, 1, -1, 0, 0, tg, tr);
    chk("lat256", 32'(tr - tg), 32'd16);

    // Stall for 3 cycles at round 5
    run_job(0, 0, 5, 3, 0, tg, tr);
    chk("lat_stall", 32'(tr - tg), 32'd15);

    // Response back-pressure for 5 cycles with a pending request
    run_job(1, 0, -1, 0, 5, tg, tr);
    run_job(0, 0, -1, 0, 0, tg2, tr2);
    chk("regrant_after_resp", 32'(tg2 - tr), 32'd6);

    // Both requesters continuously valid: alternating grants
    @(posedge clk);
    #1;
    req_type  = '0;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_grant(40, ok);
      if (ok) begin
        chk("rr_grant", 32'(req_ready), 32'(1 << exp_ptr));
        q_id.push_back(exp_ptr);
        q_cyc.push_back(cyc + 12);
        exp_ptr = (exp_ptr + 1) % NREQ;
      end
      @(posedge clk);
      #1;
      if (k == 3) req_valid = '0;
    end
    wait_idle(40);

    // Async reset in the middle of a job
    @(posedge clk);
    #1;
    req_valid = 2'b10;
    wait_grant(20, ok);
    chk("abort_grant", 32'(req_ready), 32'b10);
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int n = 0; n < 20 && core_round != 4'd7; n++) @(negedge clk);
    chk("abort_round", 32'(core_round), 32'd7);
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(reset_vec()), 32'(RESET_EXP));
    @(negedge clk);
    reset_n = 1'b1;
    exp_ptr = 0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("no_rsp_after_abort", 32'(seen), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    wait_grant(20, ok);
    chk("grant_after_reset", 32'(req_ready), 32'b01);
    if (ok) begin
      q_id.push_back(0);
      q_cyc.push_back(cyc + 12);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle(40);

    chk("pending_rsp", 32'(q_id.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
